// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and helpers for the VGA timing path.
// Every axis count in the path is COORD_W bits wide.
package vga_timing_pkg;

  localparam int COORD_W         = 10;
  localparam int COORD_MAX_TOTAL = 1 << COORD_W;

  localparam int DEF_CLK_DIV  = 2;
  localparam int DEF_SYNC_POL = 0;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_H_TOTAL      = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL      = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int DEF_H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;
  localparam int DEF_V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;

  typedef logic [COORD_W-1:0] coord_t;

  function automatic int axis_total(input int active, input int fp, input int sync,
                                    input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic coord_t next_coord(input coord_t cur, input logic at_last);
    return at_last ? '0 : cur + coord_t'(1);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: a wrapping position counter plus visible-region and sync decodes.
// The decodes are registered together with the count, so all three change on the same edge.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE   = DEF_H_ACTIVE,
  parameter int FP       = DEF_H_FP,
  parameter int SYNC     = DEF_H_SYNC,
  parameter int BP       = DEF_H_BP,
  parameter int SYNC_POL = DEF_SYNC_POL
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   step,
  output coord_t count,
  output logic   wrap,
  output logic   in_active,
  output logic   sync
);

  localparam int     TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
  localparam coord_t LAST       = coord_t'(TOTAL - 1);
  localparam coord_t ACTIVE_END = coord_t'(ACTIVE);
  localparam coord_t SYNC_START = coord_t'(ACTIVE + FP);
  localparam coord_t SYNC_END   = coord_t'(ACTIVE + FP + SYNC);
  localparam logic   SYNC_ON    = (SYNC_POL != 0);

  coord_t count_q, count_d;
  logic   in_active_q, in_active_d;
  logic   sync_q, sync_d;

  assign wrap = (count_q == LAST);

  // Decoding the next count (not the current one) aligns the levels with the count.
  always_comb begin
    count_d     = step ? next_coord(count_q, wrap) : count_q;
    in_active_d = (count_d < ACTIVE_END);
    sync_d      = ((count_d >= SYNC_START) && (count_d < SYNC_END)) ? SYNC_ON : ~SYNC_ON;
  end

  // NOTE: non-blocking assignments here so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= LAST;
      in_active_q <= 1'b0;
      sync_q      <= ~SYNC_ON;
    end else begin
      count_q     <= count_d;
      in_active_q <= in_active_d;
      sync_q      <= sync_d;
    end
  end

  assign count     = count_q;
  assign in_active = in_active_q;
  assign sync      = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel-tick divider, horizontal/vertical axes, registered sync,
// active, coordinates and the per-pixel / per-frame strobes.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int SYNC_POL = DEF_SYNC_POL
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  output logic               pix_en,
  output logic               hsync,
  output logic               vsync,
  output logic               active,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic               frame_start
);

  localparam int               H_TOTAL      = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int               V_TOTAL      = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int               DIV_W        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(CLK_DIV - 1);
  localparam coord_t           H_ACTIVE_END = coord_t'(H_ACTIVE);
  localparam coord_t           V_ACTIVE_END = coord_t'(V_ACTIVE);

  if ((H_TOTAL > COORD_MAX_TOTAL) || (V_TOTAL > COORD_MAX_TOTAL)) begin : g_total_check
    $error("vga_timing_gen: line or frame total exceeds the 10-bit coordinate range");
  end
  if (CLK_DIV < 1) begin : g_div_check
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             tick, v_step;
  coord_t           h_count, v_count, h_next, v_next;
  logic             h_wrap, v_wrap, h_in_active, v_in_active, h_sync, v_sync;
  coord_t           pixel_x_q, pixel_x_d, pixel_y_q, pixel_y_d;
  logic             pix_en_q, pix_en_d, frame_start_q, frame_start_d;

  // The divider only moves while running, so a pause resumes at the same phase.
  assign tick   = run && (div_cnt_q == DIV_LAST);
  assign v_step = tick && h_wrap;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .SYNC_POL(SYNC_POL)
  ) u_h_axis (
    .clk(clk), .rst_n(rst), .step(tick),
    .count(h_count), .wrap(h_wrap), .in_active(h_in_active), .sync(h_sync)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .SYNC_POL(SYNC_POL)
  ) u_v_axis (
    .clk(clk), .rst_n(rst), .step(v_step),
    .count(v_count), .wrap(v_wrap), .in_active(v_in_active), .sync(v_sync)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    div_cnt_d = div_cnt_q;
    if (run) begin
      div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
    end
    h_next        = next_coord(h_count, h_wrap);
    v_next        = h_wrap ? next_coord(v_count, v_wrap) : v_count;
    pix_en_d      = tick && (h_next < H_ACTIVE_END) && (v_next < V_ACTIVE_END);
    frame_start_d = tick && h_wrap && v_wrap;
    pixel_x_d     = tick ? h_next : pixel_x_q;
    pixel_y_d     = tick ? v_next : pixel_y_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_q     <= '0;
      pix_en_q      <= 1'b0;
      frame_start_q <= 1'b0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      pix_en_q      <= pix_en_d;
      frame_start_q <= frame_start_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
    end
  end

  assign pix_en      = pix_en_q;
  assign frame_start = frame_start_q;
  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign active      = h_in_active && v_in_active;
  assign hsync       = h_sync;
  assign vsync       = v_sync;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three builds (defaults, CLK_DIV=1 active-high sync, CLK_DIV=3)
// compared every cycle against a tick-count position model, plus hand-computed pins.
module tb_vga_timing_gen;

  localparam int NDUT = 3;

  typedef struct packed {
    int div; int ha; int hf; int hs; int hb; int va; int vf; int vs; int vb; int pol;
  } cfg_t;

  logic       clk = 1'b0;
  logic       rst_v  [NDUT];
  logic       run_v  [NDUT];
  logic       pe_w   [NDUT];
  logic       fs_w   [NDUT];
  logic       act_w  [NDUT];
  logic       hs_w   [NDUT];
  logic       vs_w   [NDUT];
  logic [9:0] x_w    [NDUT];
  logic [9:0] y_w    [NDUT];

  int     checks   = 0;
  int     failures = 0;
  int     run_clks [NDUT];
  longint ticks    [NDUT];
  bit     tick_now [NDUT];

  always #5 clk = ~clk;

  vga_timing_gen u_dut_a (
    .clk(clk), .rst(rst_v[0]), .run(run_v[0]), .pix_en(pe_w[0]), .hsync(hs_w[0]),
    .vsync(vs_w[0]), .active(act_w[0]), .pixel_x(x_w[0]), .pixel_y(y_w[0]),
    .frame_start(fs_w[0])
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1)
  ) u_dut_b (
    .clk(clk), .rst(rst_v[1]), .run(run_v[1]), .pix_en(pe_w[1]), .hsync(hs_w[1]),
    .vsync(vs_w[1]), .active(act_w[1]), .pixel_x(x_w[1]), .pixel_y(y_w[1]),
    .frame_start(fs_w[1])
  );

  vga_timing_gen #(
    .CLK_DIV(3), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_POL(0)
  ) u_dut_c (
    .clk(clk), .rst(rst_v[2]), .run(run_v[2]), .pix_en(pe_w[2]), .hsync(hs_w[2]),
    .vsync(vs_w[2]), .active(act_w[2]), .pixel_x(x_w[2]), .pixel_y(y_w[2]),
    .frame_start(fs_w[2])
  );

  function automatic cfg_t cfg_of(input int i);
    case (i)
      0:       return '{2, 640, 16, 96, 48, 480, 10, 2, 33, 0};
      1:       return '{1, 16, 4, 6, 6, 10, 2, 2, 3, 1};
      default: return '{3, 8, 2, 3, 3, 5, 1, 2, 2, 0};
    endcase
  endfunction

  function automatic bit is_tick(input int i, input int rc);
    return (rc % cfg_of(i).div) == (cfg_of(i).div - 1);
  endfunction

  // Expected {pix_en, frame_start, active, hsync, vsync, x, y} after n ticks since reset.
  function automatic logic [24:0] model_out(input cfg_t c, input longint n, input bit tick);
    longint ht, vt, p;
    int     h, v;
    bit     pol, a, hsv, vsv;
    ht  = c.ha + c.hf + c.hs + c.hb;
    vt  = c.va + c.vf + c.vs + c.vb;
    pol = (c.pol != 0);
    if (n == 0) return {3'b000, !pol, !pol, 20'd0};
    p   = (n - 1) % (ht * vt);
    h   = int'(p % ht);
    v   = int'(p / ht);
    a   = (h < c.ha) && (v < c.va);
    hsv = ((h >= c.ha + c.hf) && (h < c.ha + c.hf + c.hs)) ? pol : !pol;
    vsv = ((v >= c.va + c.vf) && (v < c.va + c.vf + c.vs)) ? pol : !pol;
    return {tick && a, tick && (p == 0), a, hsv, vsv, 10'(h), 10'(v)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < NDUT; i++) begin
      if (!rst_v[i]) begin
        run_clks[i] <= 0;
        ticks[i]    <= 0;
        tick_now[i] <= 1'b0;
      end else if (run_v[i]) begin
        tick_now[i] <= is_tick(i, run_clks[i]);
        ticks[i]    <= ticks[i] + (is_tick(i, run_clks[i]) ? 1 : 0);
        run_clks[i] <= run_clks[i] + 1;
      end else begin
        tick_now[i] <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("dut%0d_outputs", i),
            {pe_w[i], fs_w[i], act_w[i], hs_w[i], vs_w[i], x_w[i], y_w[i]},
            model_out(cfg_of(i), ticks[i], tick_now[i]));
    end
  end

  task automatic measure_frame(input int i, input int period, input int pix);
    bit seen;
    int pes, early;
    seen = 1'b0;
    for (int k = 0; k < 4 * period && !seen; k++) begin
      @(negedge clk);
      seen = fs_w[i];
    end
    check($sformatf("dut%0d_frame_start_seen", i), seen, 1);
    pes   = pe_w[i];
    early = 0;
    for (int k = 1; k < period; k++) begin
      @(negedge clk);
      pes   += pe_w[i];
      early += fs_w[i];
    end
    @(negedge clk);
    check($sformatf("dut%0d_frame_period", i), fs_w[i], 1);
    check($sformatf("dut%0d_pix_per_frame", i), pes, pix);
    check($sformatf("dut%0d_early_frame_start", i), early, 0);
  endtask

  initial begin
    int hs_low, pes, act_clks;
    bit found;
    for (int i = 0; i < NDUT; i++) begin
      rst_v[i]    = 1'b0;
      run_v[i]    = 1'b1;
      run_clks[i] = 0;
      ticks[i]    = 0;
      tick_now[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("a_reset_hsync", hs_w[0], 1);
    check("a_reset_pixel_x", x_w[0], 0);
    #1;
    for (int i = 0; i < NDUT; i++) rst_v[i] = 1'b1;

    // First pixel of the default build lands two clocks after release.
    @(negedge clk);
    check("a_first_clk_pix_en", pe_w[0], 0);
    @(negedge clk);
    check("a_first_pix_en", pe_w[0], 1);
    check("a_first_frame_start", fs_w[0], 1);
    check("a_first_xy", {x_w[0], y_w[0]}, 20'd0);

    // Line 0 of the default build: 1600 clocks from (0,0).
    hs_low   = (hs_w[0] == 1'b0);
    pes      = pe_w[0];
    act_clks = act_w[0];
    for (int k = 1; k < 1600; k++) begin
      @(negedge clk);
      hs_low   += (hs_w[0] == 1'b0);
      pes      += pe_w[0];
      act_clks += act_w[0];
    end
    check("a_hsync_low_clks", hs_low, 192);
    check("a_pix_en_per_line", pes, 640);
    check("a_active_clks_per_line", act_clks, 1280);
    @(negedge clk);
    check("a_line_wrap_xy", {x_w[0], y_w[0]}, {10'd0, 10'd1});

    // Pause the default build at pixel (320,1) for 37 clocks.
    found = 1'b0;
    for (int k = 0; k < 3200 && !found; k++) begin
      @(negedge clk);
      found = (x_w[0] == 10'd320) && (y_w[0] == 10'd1) && pe_w[0];
    end
    check("a_reach_320_1", found, 1);
    #1 run_v[0] = 1'b0;
    pes = 0;
    repeat (37) begin
      @(negedge clk);
      pes += pe_w[0];
    end
    check("a_pause_pix_en", pes, 0);
    check("a_pause_hold", {act_w[0], hs_w[0], x_w[0], y_w[0]}, {2'b11, 10'd320, 10'd1});
    #1 run_v[0] = 1'b1;
    @(negedge clk);
    check("a_resume_gap", pe_w[0], 0);
    @(negedge clk);
    check("a_resume_next_pixel", {pe_w[0], x_w[0]}, {1'b1, 10'd321});
    repeat (2) @(negedge clk);
    check("a_resume_spacing", {pe_w[0], x_w[0]}, {1'b1, 10'd322});

    // Async reset of the active-high-sync build inside both sync pulses.
    found = 1'b0;
    for (int k = 0; k < 1200 && !found; k++) begin
      @(negedge clk);
      found = (x_w[1] == 10'd22) && (y_w[1] == 10'd12);
    end
    check("b_reach_22_12", found, 1);
    check("b_in_sync_before_reset", {hs_w[1], vs_w[1]}, 2'b11);
    #1 rst_v[1] = 1'b0;
    #1;
    check("b_async_reset_sync", {hs_w[1], vs_w[1]}, 2'b00);
    check("b_async_reset_strobes", {pe_w[1], fs_w[1], act_w[1]}, 3'b000);
    check("b_async_reset_xy", {x_w[1], y_w[1]}, 20'd0);
    repeat (2) @(negedge clk);
    #1 rst_v[1] = 1'b1;
    @(negedge clk);
    check("b_first_pixel_after_reset", {pe_w[1], fs_w[1], x_w[1], y_w[1]}, {2'b11, 20'd0});
    measure_frame(1, 544, 160);
    measure_frame(2, 480, 40);

    // Random pauses and resets on the two small builds; the model checks every cycle.
    repeat (20000) begin
      @(negedge clk);
      #1;
      for (int i = 1; i < NDUT; i++) begin
        run_v[i] = ($urandom_range(7) != 0);
        if (!rst_v[i]) rst_v[i] = 1'b1;
        else if ($urandom_range(1999) == 0) rst_v[i] = 1'b0;
      end
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
